// File: rtl/axi_vip_0_rtl_pkg.sv
// Shared types and address helper for the AXI4 slave responder.
package axi_vip_0_rtl_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Address of the following beat; WRAP/reserved bursts are error-terminated so they hold.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == INCR) return addr + (64'd1 << size);
    return addr;
  endfunction

endpackage

// File: rtl/axi_vip_0_rtl_dpram.sv
// Byte-enabled write port plus registered read port; a same-cycle read of the
// word being written returns the old contents.
module axi_vip_0_rtl_dpram #(
  parameter  int DATA_W    = 32,
  parameter  int MEM_WORDS = 1024,
  localparam int AW        = $clog2(MEM_WORDS),
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Only the output register is cleared; the array keeps its contents across reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_vip_0_rtl_slv_responder.sv
// AXI4 slave responder backed by a word-addressed memory; independent read and
// write engines, one outstanding burst each, INCR/FIXED served, others SLVERR.
module axi_vip_0_rtl_slv_responder
  import axi_vip_0_rtl_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int RD_STALL  = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int WORD_LSB = $clog2(DATA_W / 8);
  localparam int IDX_W    = $clog2(MEM_WORDS);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+WORD_LSB-1:WORD_LSB];
  endfunction

  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return (a >> (IDX_W + WORD_LSB)) != '0;
  endfunction

  function automatic logic beat_bad(input logic [ADDR_W-1:0] a,
                                    input logic [2:0]        size,
                                    input logic [1:0]        burst);
    return (int'(size) > WORD_LSB) || burst[1] || addr_oor(a);
  endfunction

  // Holds both address channels not-ready until the first edge after reset release.
  logic ready_en;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // ---------------- write engine ----------------
  wr_state_t         wr_state, wr_state_nxt;
  logic [ID_W-1:0]   wr_id;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_len;
  logic [2:0]        wr_size;
  logic [1:0]        wr_burst;
  logic [8:0]        wr_cnt;
  logic              wr_err;
  logic              aw_hs, w_hs, wr_last, wr_bad;

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign wr_last = (wr_cnt == {1'b0, wr_len});
  assign wr_bad  = beat_bad(wr_addr, wr_size, wr_burst);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt  = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axi_awready = ready_en;
        if (s_axi_awvalid && ready_en) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        // Beat count alone ends the burst; wlast only feeds the error flag.
        if (s_axi_wvalid && wr_last) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
    end else if (aw_hs) begin
      wr_id    <= s_axi_awid;
      wr_addr  <= s_axi_awaddr;
      wr_len   <= s_axi_awlen;
      wr_size  <= s_axi_awsize;
      wr_burst <= s_axi_awburst;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
    end else if (w_hs) begin
      wr_addr <= ADDR_W'(next_addr(64'(wr_addr), wr_size, wr_burst));
      wr_cnt  <= wr_cnt + 9'd1;
      if (wr_bad || (s_axi_wlast != wr_last)) wr_err <= 1'b1;
    end
  end

  assign s_axi_bid   = wr_id;
  assign s_axi_bresp = wr_err ? SLVERR : OKAY;

  // ---------------- read engine ----------------
  rd_state_t         rd_state, rd_state_nxt;
  logic [ID_W-1:0]   rd_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic [2:0]        rd_size;
  logic [1:0]        rd_burst;
  logic [8:0]        rd_cnt;
  logic              rd_vld_p1, rd_err_p1, rd_last_p1, rd_stall_p1;
  logic [1:0]        rd_hs_cnt;
  logic              ar_hs, r_hs, rd_load;
  logic [ADDR_W-1:0] ld_addr;
  logic [8:0]        ld_cnt;
  logic              ld_bad;
  logic [DATA_W-1:0] mem_rdata;

  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign r_hs    = rd_vld_p1 & s_axi_rready;
  assign rd_load = ar_hs | (r_hs & ~rd_last_p1);

  // Address/check of the beat being fetched this cycle (first beat or the next one).
  assign ld_addr = ar_hs ? s_axi_araddr
                         : ADDR_W'(next_addr(64'(rd_addr), rd_size, rd_burst));
  assign ld_cnt  = ar_hs ? 9'd0 : rd_cnt + 9'd1;
  assign ld_bad  = ar_hs ? beat_bad(ld_addr, s_axi_arsize, s_axi_arburst)
                         : beat_bad(ld_addr, rd_size, rd_burst);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt  = rd_state;
    s_axi_arready = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axi_arready = ready_en;
        if (s_axi_arvalid && ready_en) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (rd_vld_p1 && s_axi_rready && rd_last_p1) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // ---- p1: beat presented on R, aligned with the registered memory word ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_id       <= '0;
      rd_addr     <= '0;
      rd_len      <= '0;
      rd_size     <= '0;
      rd_burst    <= '0;
      rd_cnt      <= '0;
      rd_vld_p1   <= 1'b0;
      rd_err_p1   <= 1'b0;
      rd_last_p1  <= 1'b0;
      rd_stall_p1 <= 1'b0;
      rd_hs_cnt   <= '0;
    end else if (ar_hs) begin
      rd_id       <= s_axi_arid;
      rd_addr     <= ld_addr;
      rd_len      <= s_axi_arlen;
      rd_size     <= s_axi_arsize;
      rd_burst    <= s_axi_arburst;
      rd_cnt      <= ld_cnt;
      rd_vld_p1   <= 1'b1;
      rd_err_p1   <= ld_bad;
      rd_last_p1  <= (s_axi_arlen == 8'd0);
      rd_stall_p1 <= 1'b0;
      rd_hs_cnt   <= '0;
    end else if (r_hs) begin
      rd_hs_cnt <= rd_hs_cnt + 2'd1;
      if (rd_last_p1) begin
        rd_vld_p1 <= 1'b0;
      end else begin
        rd_addr    <= ld_addr;
        rd_cnt     <= ld_cnt;
        rd_err_p1  <= ld_bad;
        rd_last_p1 <= (ld_cnt == {1'b0, rd_len});
        if ((RD_STALL != 0) && (rd_hs_cnt == 2'd3)) begin
          rd_vld_p1   <= 1'b0;
          rd_stall_p1 <= 1'b1;
        end
      end
    end else if (rd_stall_p1) begin
      rd_vld_p1   <= 1'b1;
      rd_stall_p1 <= 1'b0;
    end
  end

  assign s_axi_rvalid = rd_vld_p1;
  assign s_axi_rid    = rd_id;
  assign s_axi_rlast  = rd_last_p1;
  assign s_axi_rresp  = rd_err_p1 ? SLVERR : OKAY;
  assign s_axi_rdata  = rd_err_p1 ? '0 : mem_rdata;

  axi_vip_0_rtl_dpram #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (w_hs & ~wr_bad),
    .waddr (word_idx(wr_addr)),
    .wstrb (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (rd_load),
    .raddr (word_idx(ld_addr)),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_vip_0_rtl_slv_responder.sv
// Directed bench for the AXI4 slave responder: writes, reads, strobes, error
// paths, same-word concurrency and reset in the middle of a read burst.
module tb_axi_vip_0_rtl_slv_responder;

  localparam int LIM = 100;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd_d [256];
  logic [1:0]  rd_r [256];
  logic        rd_l [256];
  logic [3:0]  rd_id;
  int          rd_lat, rd_cnt, rd_unstable;

  always #5 aclk = ~aclk;

  axi_vip_0_rtl_slv_responder dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                           input logic [3:0] strb, input int last_at,
                           output logic [1:0] resp, output logic [3:0] bid_o);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < LIM) begin step(); n++; end
    if (n >= LIM) chk("aw_timeout", 64'(n), 64'(0));
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d0 + 32'(i); wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < LIM) begin step(); n++; end
      if (n >= LIM) chk("w_timeout", 64'(n), 64'(0));
      step();
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < LIM) begin step(); n++; end
    if (n >= LIM) chk("b_timeout", 64'(n), 64'(0));
    resp = bresp; bid_o = bid;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int n, cyc;
    bit have_snap;
    logic [38:0] snap;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIM) begin step(); n++; end
    if (n >= LIM) chk("ar_timeout", 64'(n), 64'(0));
    step();
    arvalid = 1'b0;
    rd_lat = 0;
    while (!rvalid && rd_lat < LIM) begin step(); rd_lat++; end
    rd_id = rid; rd_cnt = 0; rd_unstable = 0; cyc = 0; have_snap = 1'b0; snap = '0;
    while (rd_cnt <= int'(len) && cyc < 3000) begin
      rready = !toggle || (cyc % 2 == 1);
      if (rvalid && have_snap && ({rid, rdata, rresp, rlast} != snap)) rd_unstable++;
      if (rvalid && rready) begin
        rd_d[rd_cnt] = rdata; rd_r[rd_cnt] = rresp; rd_l[rd_cnt] = rlast;
        rd_cnt++;
        have_snap = 1'b0;
      end else if (rvalid) begin
        snap = {rid, rdata, rresp, rlast};
        have_snap = 1'b1;
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    chk("r_beats", 64'(rd_cnt), 64'(int'(len) + 1));
  endtask

  initial begin
    logic [1:0] resp;
    logic [3:0] bid_o;
    int n, hs, bad_d, bad_l;

    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) step();
    chk("rst_ready", 64'({awready, wready, arready}), 64'(0));
    chk("rst_valid", 64'({bvalid, rvalid}), 64'(0));
    chk("rst_b",     64'({bid, bresp}), 64'(0));
    chk("rst_r",     64'({rid, rdata, rresp, rlast}), 64'(0));
    aresetn = 1'b1;

    // Single write then read
    axi_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 0, resp, bid_o);
    chk("t1_bresp", 64'(resp), 64'(0));
    chk("t1_bid",   64'(bid_o), 64'(3));
    axi_read(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t1_rdata", 64'(rd_d[0]), 64'h0DEADBEEF);
    chk("t1_rresp", 64'(rd_r[0]), 64'(0));
    chk("t1_rlast", 64'(rd_l[0]), 64'(1));
    chk("t1_rid",   64'(rd_id), 64'(5));
    chk("t1_rlat",  64'(rd_lat), 64'(0));

    // INCR burst with rready toggling
    axi_write(4'd1, 32'h100, 8'd7, 3'd2, 2'b01, 32'd0, 4'hF, 7, resp, bid_o);
    chk("t2_bresp", 64'(resp), 64'(0));
    axi_read(4'd2, 32'h100, 8'd7, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_rdata", 64'(rd_d[i]), 64'(i));
      chk("t2_rlast", 64'(rd_l[i]), 64'(i == 7));
      chk("t2_rresp", 64'(rd_r[i]), 64'(0));
    end
    chk("t2_stable", 64'(rd_unstable), 64'(0));

    // Byte strobes
    axi_write(4'd0, 32'h20, 8'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, 0, resp, bid_o);
    axi_write(4'd0, 32'h20, 8'd0, 3'd2, 2'b01, 32'h00000000, 4'h5, 0, resp, bid_o);
    chk("t3_bresp", 64'(resp), 64'(0));
    axi_read(4'd0, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t3_rdata", 64'(rd_d[0]), 64'hFF00FF00);

    // Error paths
    axi_write(4'd0, 32'h0, 8'd0, 3'd2, 2'b01, 32'hA5A5A5A5, 4'hF, 0, resp, bid_o);
    chk("t4_w0", 64'(resp), 64'(0));
    axi_write(4'd7, 32'h10, 8'd1, 3'd2, 2'b10, 32'h11111111, 4'hF, 1, resp, bid_o);
    chk("t4_wrap_bresp", 64'(resp), 64'(2));
    chk("t4_wrap_bid",   64'(bid_o), 64'(7));
    axi_write(4'd0, 32'hFFFF0000, 8'd0, 3'd2, 2'b01, 32'h22222222, 4'hF, 0, resp, bid_o);
    chk("t4_oor_bresp", 64'(resp), 64'(2));
    axi_write(4'd0, 32'h40, 8'd3, 3'd2, 2'b01, 32'h50, 4'hF, 1, resp, bid_o);
    chk("t4_wlast_bresp", 64'(resp), 64'(2));
    axi_write(4'd0, 32'h10, 8'd0, 3'd3, 2'b01, 32'h33333333, 4'hF, 0, resp, bid_o);
    chk("t4_size_bresp", 64'(resp), 64'(2));
    axi_read(4'd0, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t4_keep10", 64'(rd_d[0]), 64'h0DEADBEEF);
    axi_read(4'd0, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t4_keep0", 64'(rd_d[0]), 64'h0A5A5A5A5);
    axi_read(4'd0, 32'hFFFF0000, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t4_oor_rdata", 64'(rd_d[0]), 64'(0));
    chk("t4_oor_rresp", 64'(rd_r[0]), 64'(2));
    axi_read(4'd0, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
    chk("t4_size_rdata", 64'(rd_d[0]), 64'(0));
    chk("t4_size_rresp", 64'(rd_r[0]), 64'(2));
    axi_read(4'd0, 32'h10, 8'd1, 3'd2, 2'b10, 1'b0);
    chk("t4_wrap_r0", 64'({rd_d[0], rd_r[0]}), 64'(2));
    chk("t4_wrap_r1", 64'({rd_d[1], rd_r[1], rd_l[1]}), 64'(5));

    // Concurrent AW/AR to word 0x10; beat 1 of the FIXED read meets the W beat
    awid = 4'd1; awaddr = 32'h10; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd2; araddr = 32'h10; arlen = 8'd1; arsize = 3'd2; arburst = 2'b00; arvalid = 1'b1;
    chk("t5_ready", 64'({awready, arready}), 64'(3));
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("t5_rvalid0", 64'({rvalid, wready}), 64'(3));
    chk("t5_rdata0", 64'(rdata), 64'h0DEADBEEF);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    chk("t5_rdata1", 64'({rvalid, rdata, rlast}), {31'd0, 1'b1, 32'hDEADBEEF, 1'b1});
    chk("t5_b", 64'({bvalid, bresp, bid}), 64'({1'b1, 2'b00, 4'd1}));
    step();
    rready = 1'b0; bready = 1'b0;
    chk("t5_idle", 64'({rvalid, bvalid, arready, awready}), 64'(3));
    axi_read(4'd0, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t5_after", 64'(rd_d[0]), 64'h0CAFEF00D);

    // len=255 FIXED read: 256 beats, rlast only on the final one
    axi_read(4'd9, 32'h20, 8'd255, 3'd2, 2'b00, 1'b0);
    bad_d = 0; bad_l = 0;
    for (int i = 0; i < 256; i++) begin
      if (rd_d[i] !== 32'hFF00FF00) bad_d++;
      if (rd_l[i] !== (i == 255)) bad_l++;
    end
    chk("t6_data", 64'(bad_d), 64'(0));
    chk("t6_rlast", 64'(bad_l), 64'(0));

    // Reset during beat 3 of a 16-beat read
    arid = 4'd6; araddr = 32'h100; arlen = 8'd15; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIM) begin step(); n++; end
    if (n >= LIM) chk("t7_ar_timeout", 64'(n), 64'(0));
    step();
    arvalid = 1'b0; rready = 1'b1; hs = 0; n = 0;
    while (hs < 3 && n < LIM) begin
      if (rvalid) hs++;
      step();
      n++;
    end
    chk("t7_beat3", 64'({rvalid, rdata}), {31'd0, 1'b1, 32'd3});
    aresetn = 1'b0;
    #1;
    chk("t7_valids", 64'({rvalid, bvalid}), 64'(0));
    chk("t7_readys", 64'({arready, awready, wready}), 64'(0));
    chk("t7_r", 64'({rid, rresp, rlast}), 64'(0));
    rready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    axi_read(4'd4, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t7_fresh", 64'({rd_d[0], rd_r[0], rd_l[0]}), {29'd0, 32'hCAFEF00D, 2'b00, 1'b1});
    chk("t7_rid", 64'(rd_id), 64'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_vip_0_rtl_slv_responder.md
Name: axi_vip_0_rtl_slv_responder

Overview:
- Synthesizable AXI4 slave responder with an internal word-addressed memory.
- Connects to the master/passthrough VIP path in the ex_sim bench and replaces the slave VIP as the responding end.
- Serves INCR and FIXED bursts with one outstanding transaction per direction; read and write channels run independently.
- Lets the master stimulus and scoreboard run against real RTL instead of a VIP-generated response.

Parameters:
- ID_W, 4, width of AWID/ARID/BID/RID.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; must be 32 or 64.
- MEM_WORDS, 1024, memory depth in DATA_W words; must be a power of 2.
- RD_STALL, 0, when 1, rvalid deasserts for one cycle after every 4th accepted beat (backpressure test).

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst, in, ID_W/ADDR_W/8/3/2, write address.
- s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata/wstrb/wlast, in, DATA_W/DATA_W/8/1.
- s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bid/bresp, out, ID_W/2.
- s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_arid/araddr/arlen/arsize/arburst, in, ID_W/ADDR_W/8/3/2.
- s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rid/rdata/rresp/rlast, out, ID_W/DATA_W/2/1.
- s_axi_rvalid out 1; s_axi_rready in 1.

Behaviour:
- Clock and reset: one clock aclk; aresetn is asynchronous assert, synchronous deassert, active-low.
- Reset state:
  - All valid/ready outputs are 0.
  - bid, bresp, rid, rdata, rresp, rlast are 0.
  - Both FSMs return to IDLE.
  - Memory contents are not reset.
- Reset mid-burst: the burst is abandoned, with no partial B or R response.
- Write FSM states:
  - W_IDLE: awready=1. On AW handshake, latch id, address, len, size and burst, then go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write bytes enabled by wstrb and advance the address per burst type.
    - When the beat count reaches len+1, go to W_RESP.
    - Exit to W_RESP on the beat count only; wlast is ignored for control.
    - If wlast disagrees with the beat count, set an internal protocol-error flag that forces bresp=SLVERR.
  - W_RESP: bvalid=1 starting the cycle after the last W handshake. Hold until bready, then go to W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1. On AR handshake, latch the fields, then go to R_DATA.
  - R_DATA: rvalid is asserted the cycle after the AR handshake.
    - rdata is registered from memory.
    - rlast=1 on beat len.
    - Advance on each R handshake; hold all R outputs stable while rready=0.
    - After the last handshake, go to R_IDLE; arready reasserts the next cycle.
- Address arithmetic:
  - Word index = addr[log2(MEM_WORDS)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
  - INCR adds 2^size bytes per beat.
  - FIXED leaves the address unchanged.
  - WRAP (2'b10) and reserved (2'b11) bursts are accepted and complete with SLVERR on every beat/response. Writes are dropped and reads return 0.
- awsize or arsize above log2(DATA_W/8): the response is SLVERR and the data is ignored or returned as 0.
- Out-of-range address (upper address bits nonzero beyond the memory span, checked per beat):
  - Writes: that beat is dropped and bresp=SLVERR.
  - Reads: that beat returns 0 with rresp=SLVERR.
- Normal response is OKAY (2'b00).
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-before-write).
- len=0 is a single beat; len=255 gives 256 beats, and the beat counter is 9 bits.
- RD_STALL=1: after every 4th R handshake, rvalid=0 for exactly one cycle.

Decomposition:
- Package axi_vip_0_rtl_pkg:
  - resp_t constants OKAY=2'b00, SLVERR=2'b10.
  - burst_t constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - wr_state_t and rd_state_t enums.
  - Function next_addr(addr, size, burst).
- Sub-module axi_vip_0_rtl_dpram:
  - One write port with byte enables.
  - One synchronous read port, read-before-write.
  - Depth MEM_WORDS.

Test Plan:
1. Single write then read: AW addr 0x10, len 0, data 0xDEADBEEF, strb 0xF. Expect B with OKAY and bid equal to awid. AR addr 0x10 returns 0xDEADBEEF, OKAY, rlast=1, with rvalid the cycle after arready.
2. INCR burst: write addr 0x100, len 7, data 0..7. Read back len 7 with rready toggling every other cycle. Expect 0..7 in order, rlast only on beat 8, and outputs stable while rready=0.
3. Byte strobes: write 0xFFFFFFFF to 0x20, then 0x00000000 with strb 0x5. Expect read value 0xFF00FF00.
4. Error paths, each expecting SLVERR and no memory change:
   - WRAP burst.
   - awaddr 0xFFFF_0000.
   - Write with an early wlast.
   - Read of the out-of-range address returns 0 with SLVERR.
5. Concurrency: issue AW and AR to the same word in the same cycle. Expect both handshakes to complete and the read to return the pre-write value.
6. Reset mid-burst: drop aresetn during beat 3 of a len 15 read. Expect all valids to go to 0 immediately, and a fresh single-beat read to complete correctly after release.
